// File: rtl/ysyx_24100006_lsu_if.sv
// ysyx_24100006_lsu_if: EXEU-side, WBU-side and memory-bus handshakes of the load/store unit
interface ysyx_24100006_lsu_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int SIDE_W = 64
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_W-1:0]     in_addr;
   logic [DATA_W-1:0]     in_wdata;
   logic                  in_read;
   logic                  in_write;
   logic [1:0]            in_size;
   logic                  in_unsigned;
   logic [SIDE_W-1:0]     in_side;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_W-1:0]     out_rdata;
   logic [SIDE_W-1:0]     out_side;
   logic                  out_err;
   logic [1:0]            out_err_code;
   logic                  bus_req_valid;
   logic                  bus_req_ready;
   logic [ADDR_W-1:0]     bus_req_addr;
   logic                  bus_req_write;
   logic [DATA_W-1:0]     bus_req_wdata;
   logic [DATA_W/8-1:0]   bus_req_wstrb;
   logic                  bus_resp_valid;
   logic                  bus_resp_ready;
   logic [DATA_W-1:0]     bus_resp_data;
   logic                  bus_resp_err;
   modport master (
      input  in_valid, in_addr, in_wdata, in_read, in_write, in_size, in_unsigned, in_side,
      input  out_ready, bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err,
      output in_ready, out_valid, out_rdata, out_side, out_err, out_err_code,
      output bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb, bus_resp_ready
   );
   modport slave (
      output in_valid, in_addr, in_wdata, in_read, in_write, in_size, in_unsigned, in_side,
      output out_ready, bus_req_ready, bus_resp_valid, bus_resp_data, bus_resp_err,
      input  in_ready, out_valid, out_rdata, out_side, out_err, out_err_code,
      input  bus_req_valid, bus_req_addr, bus_req_write, bus_req_wdata, bus_req_wstrb, bus_resp_ready
   );
endinterface

// File: rtl/ysyx_24100006_lsu.sv
// ysyx_24100006_lsu: valid/ready load/store unit; define LSU_TIMEOUT_EN to add a bus-response timeout
module ysyx_24100006_lsu #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int SIDE_W      = 64,
   parameter int TIMEOUT_CYC = 1023
) (
   input logic clk,
   input logic reset,
   ysyx_24100006_lsu_if.master lsu
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              read, write, uns;
   logic [1:0]        size;
   logic [SIDE_W-1:0] side;
   logic [DATA_W-1:0] rdata, rdata_nx;
   logic [1:0]        code, code_nx;
   logic [OFF_W-1:0]  off;
   logic [DATA_W-1:0] shifted, keep, load;
   logic              sgn, fire, misaligned;
   logic [2:0]        in_align;
   logic [7:0]        mask;

   assign fire       = lsu.in_valid && state == IDLE;
   assign in_align   = lsu.in_size == 2'd0 ? 3'd0 : lsu.in_size == 2'd1 ? 3'd1 : lsu.in_size == 2'd2 ? 3'd3 : 3'd7;
   assign misaligned = |(lsu.in_addr[2:0] & in_align) || (lsu.in_size == 2'd3 && DATA_W < 64);
   assign off        = addr[OFF_W-1:0];
   assign mask       = size == 2'd0 ? 8'h01 : size == 2'd1 ? 8'h03 : size == 2'd2 ? 8'h0f : 8'hff;
   assign shifted    = lsu.bus_resp_data >> {off, 3'b000};
   assign keep       = size == 2'd0 ? DATA_W'(8'hff) : size == 2'd1 ? DATA_W'(16'hffff) :
                       size == 2'd2 ? DATA_W'(32'hffff_ffff) : '1;
   assign sgn        = !uns && (size == 2'd0 ? shifted[7] : size == 2'd1 ? shifted[15] :
                                size == 2'd2 ? shifted[31] : shifted[DATA_W-1]);
   assign load       = (shifted & keep) | (sgn ? ~keep : '0);

   assign lsu.in_ready       = state == IDLE;
   assign lsu.out_valid      = state == DONE;
   assign lsu.bus_req_valid  = state == REQ;
   assign lsu.bus_resp_ready = state == RESP;
   assign lsu.out_rdata      = rdata;
   assign lsu.out_side       = side;
   assign lsu.out_err        = |code;
   assign lsu.out_err_code   = code;
   assign lsu.bus_req_addr   = addr & ~ADDR_W'(BYTES - 1);
   assign lsu.bus_req_write  = write;
   assign lsu.bus_req_wdata  = wdata << {off, 3'b000};
   assign lsu.bus_req_wstrb  = BYTES'(mask) << off;

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt;
   logic             expired;
   assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1);
   // cycles spent in RESP without a response; cleared outside RESP so it restarts on every entry
   always_ff @(posedge clk)
      if (reset || state != RESP) cnt <= '0;
      else if (!lsu.bus_resp_valid) cnt <= cnt + CNT_W'(1);
`endif

   // next state and the result that will be presented in DONE
   always_comb begin
      state_nx = state;
      rdata_nx = rdata;
      code_nx  = code;
      case (state)
         IDLE: if (fire) begin
            if (!(lsu.in_read || lsu.in_write)) begin
               state_nx = DONE;
               rdata_nx = '0;
               code_nx  = 2'd0;
            end else if (misaligned) begin
               state_nx = DONE;
               rdata_nx = '0;
               code_nx  = 2'd1;
            end else state_nx = REQ;
         end
         REQ: if (lsu.bus_req_ready) state_nx = RESP;
         RESP: if (lsu.bus_resp_valid) begin
            state_nx = DONE;
            rdata_nx = (lsu.bus_resp_err || write) ? '0 : load;
            code_nx  = lsu.bus_resp_err ? 2'd2 : 2'd0;
         end
`ifdef LSU_TIMEOUT_EN
         else if (expired) begin
            state_nx = DONE;
            rdata_nx = '0;
            code_nx  = 2'd3;
         end
`endif
         DONE: if (lsu.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;

   // request capture and result registers
   always_ff @(posedge clk)
      if (reset) begin
         addr  <= '0;
         wdata <= '0;
         read  <= 1'b0;
         write <= 1'b0;
         size  <= 2'd0;
         uns   <= 1'b0;
         side  <= '0;
         rdata <= '0;
         code  <= 2'd0;
      end else begin
         if (fire) begin
            addr  <= lsu.in_addr;
            wdata <= lsu.in_wdata;
            read  <= lsu.in_read;
            write <= lsu.in_write;
            size  <= lsu.in_size;
            uns   <= lsu.in_unsigned;
            side  <= lsu.in_side;
         end
         rdata <= rdata_nx;
         code  <= code_nx;
      end

   logic unused;
   assign unused = read;
endmodule
